prv_trap_sequencer: RTL

//  Prioritises pending exceptions, interrupts and xRET, then runs the multi-cycle trap/return sequence:

---
 rtl/prv_trap_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer: prioritise exceptions/interrupts/MRET and sequence flush -> CSR update -> PC redirect.
// Ports: clk_i/rst_ni (async active-low); exc_vec_i, curr_epc_i, curr_epc_p4_i, int_vec_i, int_en_i,
//   glob_ie_i, ret_i, mtvec_i, mepc_i, flush_ack_i in; flush_req_o, epc_we_o/epc_wdata_o,
//   cause_we_o/cause_wdata_o, mstatus_push_o, mstatus_pop_o, redirect_valid_o/redirect_addr_o,
//   intr_o, busy_o out.
// Option: TRAP_VECTORED_EN enables vectored interrupt targets when mtvec mode is 2'b01.
module prv_trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [8:0]      exc_vec_i,
  input  logic [XLEN-1:0] curr_epc_i,
  input  logic [XLEN-1:0] curr_epc_p4_i,
  input  logic [2:0]      int_vec_i,
  input  logic [2:0]      int_en_i,
  input  logic            glob_ie_i,
  input  logic            ret_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            flush_ack_i,
  output logic            flush_req_o,
  output logic            epc_we_o,
  output logic [XLEN-1:0] epc_wdata_o,
  output logic            cause_we_o,
  output logic [XLEN-1:0] cause_wdata_o,
  output logic            mstatus_push_o,
  output logic            mstatus_pop_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_addr_o,
  output logic            intr_o,
  output logic            busy_o
);
  typedef enum logic [2:0] {IDLE, FLUSH, SAVE, RESTORE, REDIRECT} state_e;
  state_e state_q, state_d;
  logic ret_q, ret_d, int_q, int_d;
  logic [3:0] code_q, code_d;
  logic [XLEN-1:0] epc_q, epc_d, addr_q, addr_d;
  logic [2:0] pend;
  logic trap, is_int;
  logic [3:0] code;
  logic [XLEN-1:0] base, trap_addr;
  assign pend   = int_vec_i & int_en_i & {3{glob_ie_i}};
  assign intr_o = |pend;
  assign is_int = |pend;
  assign trap   = is_int | (|exc_vec_i);
  // Interrupts outrank exceptions; within each group the fixed order below applies.
  assign code = pend[2]      ? 4'd11 :
                pend[1]      ? 4'd3  :
                pend[0]      ? 4'd7  :
                exc_vec_i[8] ? 4'd1  :
                exc_vec_i[7] ? 4'd0  :
                exc_vec_i[6] ? 4'd2  :
                exc_vec_i[5] ? 4'd3  :
                exc_vec_i[4] ? 4'd11 :
                exc_vec_i[3] ? 4'd4  :
                exc_vec_i[2] ? 4'd5  :
                exc_vec_i[1] ? 4'd6  : 4'd7;
  assign base = mtvec_i & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
  assign trap_addr = (is_int && mtvec_i[1:0] == 2'b01) ? base + (XLEN'(code) << 2) : base;
`else
  assign trap_addr = base;
`endif
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    int_d   = int_q;
    code_d  = code_q;
    epc_d   = epc_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        // A trap in the same cycle as MRET wins; the return is dropped.
        if (trap) begin
          state_d = FLUSH;
          ret_d   = 1'b0;
          int_d   = is_int;
          code_d  = code;
          epc_d   = is_int ? curr_epc_p4_i : curr_epc_i;
          addr_d  = trap_addr;
        end else if (ret_i) begin
          state_d = FLUSH;
          ret_d   = 1'b1;
          int_d   = 1'b0;
          code_d  = 4'd0;
        end
      end
      FLUSH:    state_d = flush_ack_i ? (ret_q ? RESTORE : SAVE) : FLUSH;
      SAVE:     state_d = REDIRECT;
      RESTORE: begin
        state_d = REDIRECT;
        addr_d  = mepc_i;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ret_q   <= 1'b0;
      int_q   <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      int_q   <= int_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      addr_q  <= addr_d;
    end
  end
  assign flush_req_o      = state_q == FLUSH;
  assign epc_we_o         = state_q == SAVE;
  assign cause_we_o       = state_q == SAVE;
  assign mstatus_push_o   = state_q == SAVE;
  assign mstatus_pop_o    = state_q == RESTORE;
  assign redirect_valid_o = state_q == REDIRECT;
  assign busy_o           = state_q != IDLE;
  assign epc_wdata_o      = epc_q;
  assign cause_wdata_o    = {int_q, {(XLEN-5){1'b0}}, code_q};
  assign redirect_addr_o  = addr_q;
endmodule
